// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one peripheral/data bus between m0 (CPU MEM stage, priority)
// and m1 (DMA/boot loader) with a req/ack handshake and a starvation guard for m1.
module bus_arbiter #(
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned STARVE_LIM  = 4,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter bit          M1_PERIPH   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        bus_en,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_din,
    input  logic [31:0] bus_dout,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic        owner_q, owner_d;      // 1: current transaction belongs to m1
    logic        err_q, err_d;
    logic        first_q, first_d;
    logic        bus_wen_q, bus_wen_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_din_q, bus_din_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        m1_wins, m1_refused;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        err_d      = err_q;
        first_d    = first_q;
        bus_wen_d  = bus_wen_q;
        bus_addr_d = bus_addr_q;
        bus_din_d  = bus_din_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m1_wins    = m1_req && (!m0_req || (starve_q >= 4'(STARVE_LIM)));
        m1_refused = !M1_PERIPH && (m1_addr >= PERIPH_BASE);

        case (state_q)
            IDLE: begin
                if (!m1_req)
                    starve_d = 4'd0;
                if (m1_wins) begin
                    owner_d  = 1'b1;
                    starve_d = 4'd0;
                    if (m1_refused) begin
                        // refused requests never touch the bus
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d      = 1'b0;
                        bus_wen_d  = m1_wen;
                        bus_addr_d = m1_addr;
                        bus_din_d  = m1_wdata;
                        cnt_d      = 3'd0;
                        first_d    = 1'b1;
                        state_d    = ACCESS;
                    end
                end else if (m0_req) begin
                    owner_d    = 1'b0;
                    err_d      = 1'b0;
                    bus_wen_d  = m0_wen;
                    bus_addr_d = m0_addr;
                    bus_din_d  = m0_wdata;
                    cnt_d      = 3'd0;
                    first_d    = 1'b1;
                    state_d    = ACCESS;
                    if (m1_req && starve_q != 4'hF)
                        starve_d = starve_q + 4'd1;
                end
            end
            ACCESS: begin
                first_d = 1'b0;
                if (cnt_q == 3'(RD_LAT)) begin
                    if (!bus_wen_q) begin
                        if (owner_q)
                            m1_rdata_d = bus_dout;
                        else
                            m0_rdata_d = bus_dout;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            starve_q   <= 4'd0;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
            first_q    <= 1'b0;
            bus_wen_q  <= 1'b0;
            bus_addr_q <= 32'd0;
            bus_din_q  <= 32'd0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
            first_q    <= first_d;
            bus_wen_q  <= bus_wen_d;
            bus_addr_q <= bus_addr_d;
            bus_din_q  <= bus_din_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // write strobe only in the first ACCESS cycle so each write lands once
    assign bus_en   = (state_q == ACCESS);
    assign bus_wen  = bus_en && first_q && bus_wen_q;
    assign bus_addr = bus_addr_q;
    assign bus_din  = bus_din_q;
    assign m0_ack   = (state_q == DONE) && !owner_q;
    assign m1_ack   = (state_q == DONE) && owner_q;
    assign m1_err   = (state_q == DONE) && owner_q && err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus a randomized transaction-level scoreboard
// for bus_arbiter, with a small behavioural bus slave (16 memory + 16 peripheral words).
module tb_bus_arbiter;

    localparam int          RD_LAT      = 1;
    localparam int          STARVE_LIM  = 4;
    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
    localparam int          TIMEOUT     = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wen, m0_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_wen, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        bus_en, bus_wen, busy;
    logic [31:0] bus_addr, bus_din, bus_dout;

    int tests  = 0;
    int errors = 0;

    logic [31:0] bus_mem [0:31];
    logic        mem_init, poke_en;
    logic [4:0]  poke_idx;
    logic [31:0] poke_data;
    int          en_cycles  = 0;
    int          wen_cycles = 0;
    int          m0_acks    = 0;
    int          m1_acks    = 0;

    bus_arbiter #(
        .RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM),
        .PERIPH_BASE(PERIPH_BASE), .M1_PERIPH(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .bus_en(bus_en), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_din(bus_din),
        .bus_dout(bus_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // word index: bit 30 selects peripheral bank, bits 5:2 the word
    function automatic logic [4:0] bus_idx(input logic [31:0] a);
        return {a[30], a[5:2]};
    endfunction

    assign bus_dout = bus_mem[bus_idx(bus_addr)];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) bus_mem[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (poke_en) begin
            bus_mem[poke_idx] <= poke_data;
        end else if (bus_en && bus_wen) begin
            bus_mem[bus_idx(bus_addr)] <= bus_din;
        end
        if (bus_en)  en_cycles  <= en_cycles + 1;
        if (bus_wen) wen_cycles <= wen_cycles + 1;
        if (m0_ack)  m0_acks    <= m0_acks + 1;
        if (m1_ack)  m1_acks    <= m1_acks + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [4:0] idx, input logic [31:0] data);
        poke_en = 1'b1; poke_idx = idx; poke_data = data;
        step();
        poke_en = 1'b0;
    endtask

    // n = edges after the request was driven until ack is visible
    task automatic wait_ack(input string name, output int n, output logic a0, output logic a1);
        n = 0; a0 = 1'b0; a1 = 1'b0;
        while (n < TIMEOUT) begin
            step();
            n++;
            if (m0_ack || m1_ack) begin
                a0 = m0_ack; a1 = m1_ack;
                break;
            end
        end
        if (!(a0 || a1)) begin
            tests++; errors++;
            $display("FAIL %s: no ack within %0d cycles", name, TIMEOUT);
        end
    endtask

    task automatic test_reset();
        step(); step();
        tests++;
        if ({busy, bus_en, bus_wen, m0_ack, m1_ack, m1_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset ctrl: got %b expected 000000", {busy, bus_en, bus_wen, m0_ack, m1_ack, m1_err});
        end
        tests++;
        if (bus_addr !== 32'd0 || bus_din !== 32'd0) begin
            errors++; $display("FAIL reset bus: addr %h din %h expected 0", bus_addr, bus_din);
        end
        tests++;
        if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
            errors++; $display("FAIL reset rdata: m0 %h m1 %h expected 0", m0_rdata, m1_rdata);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_m0_read();
        int n, e0;
        logic a0, a1;
        poke(5'd4, 32'hDEAD_BEEF);
        e0 = en_cycles;
        m0_wen = 1'b0; m0_addr = 32'h0000_0010; m0_req = 1'b1;
        wait_ack("m0_read", n, a0, a1);
        m0_req = 1'b0;
        // the requester captures ack on the edge after it becomes visible
        tests++;
        if (n + 1 != RD_LAT + 3) begin
            errors++; $display("FAIL m0_read latency: got %0d expected %0d", n + 1, RD_LAT + 3);
        end
        tests++;
        if (!(a0 && !a1)) begin
            errors++; $display("FAIL m0_read grant: got m0_ack %b m1_ack %b expected 1 0", a0, a1);
        end
        tests++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL m0_read data: got %h expected deadbeef", m0_rdata);
        end
        step();
        tests++;
        if (en_cycles - e0 != RD_LAT + 1) begin
            errors++; $display("FAIL m0_read bus_en cycles: got %0d expected %0d", en_cycles - e0, RD_LAT + 1);
        end
    endtask

    task automatic test_m0_write_led();
        int n, w0, k0;
        logic a0, a1;
        w0 = wen_cycles; k0 = m0_acks;
        m0_wen = 1'b1; m0_addr = 32'h4000_000C; m0_wdata = 32'h0000_00A5; m0_req = 1'b1;
        wait_ack("led_write", n, a0, a1);
        m0_req = 1'b0;
        step(); step();
        tests++;
        if (wen_cycles - w0 != 1) begin
            errors++; $display("FAIL led_write bus_wen cycles: got %0d expected 1", wen_cycles - w0);
        end
        tests++;
        if (bus_mem[19] !== 32'h0000_00A5) begin
            errors++; $display("FAIL led_write LED: got %h expected 000000a5", bus_mem[19]);
        end
        tests++;
        if (m0_acks - k0 != 1) begin
            errors++; $display("FAIL led_write ack pulses: got %0d expected 1", m0_acks - k0);
        end
        tests++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL led_write rdata kept: got %h expected deadbeef", m0_rdata);
        end
    endtask

    task automatic test_m1_refused();
        int n, e0;
        logic a0, a1, err;
        poke(5'd20, 32'h5555_1234);
        e0 = en_cycles;
        m1_wen = 1'b1; m1_addr = 32'h4000_0010; m1_wdata = 32'hFFFF_FFFF; m1_req = 1'b1;
        wait_ack("m1_refused", n, a0, a1);
        err = m1_err;
        m1_req = 1'b0;
        step(); step();
        tests++;
        if (n + 1 != 2) begin
            errors++; $display("FAIL m1_refused latency: got %0d expected 2", n + 1);
        end
        tests++;
        if (!(a1 && err && !a0)) begin
            errors++; $display("FAIL m1_refused ack/err: got ack %b err %b expected 1 1", a1, err);
        end
        tests++;
        if (en_cycles != e0) begin
            errors++; $display("FAIL m1_refused bus_en cycles: got %0d expected 0", en_cycles - e0);
        end
        tests++;
        if (bus_mem[20] !== 32'h5555_1234) begin
            errors++; $display("FAIL m1_refused SSDT: got %h expected 55551234", bus_mem[20]);
        end
    endtask

    task automatic test_drop();
        int n;
        logic a0, a1;
        m0_wen = 1'b0; m0_addr = 32'h0000_0014; m0_req = 1'b1;
        step();
        m0_req = 1'b0;
        wait_ack("drop", n, a0, a1);
        tests++;
        if (!a0 || m0_rdata !== 32'hC0DE_0005) begin
            errors++; $display("FAIL drop: got ack %b data %h expected 1 c0de0005", a0, m0_rdata);
        end
        step(); step();
    endtask

    task automatic test_starvation();
        int n, skipped, exp1;
        logic a0, a1;
        skipped = 0;
        m0_wen = 1'b0; m0_addr = 32'h0000_0008; m0_req = 1'b1;
        m1_wen = 1'b0; m1_addr = 32'h0000_000C; m1_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (skipped >= STARVE_LIM) begin exp1 = 1; skipped = 0; end
            else begin exp1 = 0; skipped++; end
            wait_ack("starve", n, a0, a1);
            tests++;
            if ({a0, a1} !== {exp1 == 0, exp1 == 1}) begin
                errors++;
                $display("FAIL starve grant %0d: got m0 %b m1 %b expected m%0d", k, a0, a1, exp1);
            end
            if (!(a0 || a1)) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        int n, k0;
        logic a0, a1;
        k0 = m0_acks;
        m0_wen = 1'b0; m0_addr = 32'h0000_0010; m0_req = 1'b1;
        step(); step();
        reset = 1'b1; m0_req = 1'b0;
        step();
        tests++;
        if ({busy, bus_en, bus_wen, m0_ack, m1_ack, m1_err} !== 6'b0 ||
            m0_rdata !== 32'd0 || m1_rdata !== 32'd0 || bus_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid outputs: ctrl %b m0_rdata %h m1_rdata %h addr %h expected all 0",
                     {busy, bus_en, bus_wen, m0_ack, m1_ack, m1_err}, m0_rdata, m1_rdata, bus_addr);
        end
        reset = 1'b0;
        step(); step();
        tests++;
        if (m0_acks != k0) begin
            errors++; $display("FAIL reset_mid stray ack: got %0d acks expected 0", m0_acks - k0);
        end
        m0_req = 1'b1;
        wait_ack("reset_mid reissue", n, a0, a1);
        m0_req = 1'b0;
        tests++;
        if (!a0 || n + 1 != RD_LAT + 3 || m0_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reset_mid reissue: ack %b latency %0d data %h expected 1 %0d deadbeef",
                     a0, n + 1, m0_rdata, RD_LAT + 3);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        logic a0, a1;
        m1_wen = 1'b0; m1_addr = 32'h0000_0000; m1_req = 1'b1;
        wait_ack("b2b first", n, a0, a1);
        tests++;
        if (!a1 || m1_rdata !== 32'hC0DE_0000) begin
            errors++; $display("FAIL b2b first: ack %b data %h expected 1 c0de0000", a1, m1_rdata);
        end
        m1_addr = 32'h0000_0004;
        wait_ack("b2b second", n, a0, a1);
        m1_req = 1'b0;
        tests++;
        if (!a1 || n != RD_LAT + 3 || m1_rdata !== 32'hC0DE_0001) begin
            errors++;
            $display("FAIL b2b second: ack %b spacing %0d data %h expected 1 %0d c0de0001",
                     a1, n, m1_rdata, RD_LAT + 3);
        end
        step(); step();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        base = ($urandom_range(0, 3) == 0) ? PERIPH_BASE : 32'd0;
        return base | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    // transaction-level model: arbitration rule, starvation count and memory image
    task automatic test_random();
        logic [31:0] exp_mem [0:31];
        logic [31:0] addr, wdata, exp_rd, got_rd;
        logic        p0, p1, in_done, win1, refused, wen, a0, a1;
        int          starve, done_cnt, n, exp_n;
        mem_init = 1'b1; step(); mem_init = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = 32'hC0DE_0000 + 32'(i);
        p0 = 1'b0; p1 = 1'b0; in_done = 1'b0; starve = 0; done_cnt = 0;
        while (done_cnt < 150) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1; m0_wen = 1'($urandom_range(0, 1)); m0_addr = rand_addr(); m0_wdata = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; m1_wen = 1'($urandom_range(0, 1)); m1_addr = rand_addr(); m1_wdata = $urandom;
            end
            m0_req = p0; m1_req = p1;
            if (!p0 && !p1) begin
                step();
                if (!in_done) starve = 0;
                in_done = 1'b0;
                continue;
            end
            win1 = p1 && (!p0 || starve >= STARVE_LIM);
            if (win1)    starve = 0;
            else if (p1) starve = (starve < 15) ? starve + 1 : 15;
            else         starve = 0;
            addr    = win1 ? m1_addr : m0_addr;
            wen     = win1 ? m1_wen : m0_wen;
            wdata   = win1 ? m1_wdata : m0_wdata;
            refused = win1 && (addr >= PERIPH_BASE);
            exp_rd  = exp_mem[bus_idx(addr)];
            exp_n   = (refused ? 1 : RD_LAT + 2) + (in_done ? 1 : 0);
            wait_ack("random", n, a0, a1);
            if (!(a0 || a1)) break;
            tests++;
            if ({a0, a1} !== {!win1, win1}) begin
                errors++; $display("FAIL random grant %0d: got m0 %b m1 %b expected m%0d", done_cnt, a0, a1, win1);
            end
            tests++;
            if (n != exp_n) begin
                errors++; $display("FAIL random latency %0d: got %0d expected %0d", done_cnt, n, exp_n);
            end
            if (win1) begin
                tests++;
                if (m1_err !== refused) begin
                    errors++; $display("FAIL random m1_err %0d: got %b expected %b", done_cnt, m1_err, refused);
                end
            end
            if (!refused && !wen) begin
                got_rd = win1 ? m1_rdata : m0_rdata;
                tests++;
                if (got_rd !== exp_rd) begin
                    errors++; $display("FAIL random rdata %0d: got %h expected %h", done_cnt, got_rd, exp_rd);
                end
            end
            if (!refused && wen) exp_mem[bus_idx(addr)] = wdata;
            if (win1) begin p1 = 1'b0; m1_req = 1'b0; end
            else      begin p0 = 1'b0; m0_req = 1'b0; end
            in_done = 1'b1;
            done_cnt++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step(); step();
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1; poke_en = 1'b0; poke_idx = 5'd0; poke_data = 32'd0;
        m0_req = 1'b0; m0_wen = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_wen = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        step();
        mem_init = 1'b0;
        test_reset();
        test_m0_read();
        test_m0_write_led();
        test_m1_refused();
        test_drop();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
